sys_bus_ctrl: RTL

//  Data-side system bus slave driven directly by the core's sys_bus_* outputs.
//  - Decodes each bus access to a word-organised data RAM or a memory-mapped timer.
//  - Performs byte/half/word lane steering and detects misaligned accesses.
//  - Returns read data registered, so it is valid in the core's MEM cycle.

---
 rtl/sys_bus_ctrl_pkg.sv | 81 ++++++++
 rtl/bus_timer.sv | 113 +++++++++++
 rtl/sys_bus_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/sys_bus_ctrl_pkg.sv
// sys_bus_ctrl_pkg
//   Shared definitions for the data-side system bus slave:
//   - core access-type encoding (width and enum)
//   - timer register offsets and CTRL bit indices
//   - address-window decode, access classification and byte-lane helpers
package sys_bus_ctrl_pkg;

   localparam int unsigned MEM_ACCESS_TYPE_WIDTH = 3;

   typedef enum logic [MEM_ACCESS_TYPE_WIDTH-1:0] {
      ACC_NONE       = 3'd0,
      ACC_READ_BYTE  = 3'd1,
      ACC_READ_HALF  = 3'd2,
      ACC_READ_WORD  = 3'd3,
      ACC_WRITE_BYTE = 3'd4,
      ACC_WRITE_HALF = 3'd5,
      ACC_WRITE_WORD = 3'd6
   } mem_access_e;

   typedef enum logic [1:0] {
      SZ_BYTE,
      SZ_HALF,
      SZ_WORD
   } acc_size_e;

   // Timer register offsets inside the 32-byte timer window
   localparam logic [4:0] TMR_CTRL  = 5'h00;
   localparam logic [4:0] TMR_PRESC = 5'h04;
   localparam logic [4:0] TMR_COUNT = 5'h08;
   localparam logic [4:0] TMR_CMP   = 5'h0C;
   localparam logic [4:0] TMR_STAT  = 5'h10;
   localparam logic [4:0] TMR_ERR   = 5'h14;

   localparam logic [31:0] TMR_WINDOW_BYTES = 32'd32;

   // CTRL bit indices
   localparam int unsigned CTRL_EN          = 0;
   localparam int unsigned CTRL_IRQ_EN      = 1;
   localparam int unsigned CTRL_AUTO_RELOAD = 2;

   // Unsigned subtraction makes addresses below base wrap to a huge offset
   function automatic logic in_window(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] size_bytes);
      return (addr - base) < size_bytes;
   endfunction

   function automatic logic acc_is_read(input mem_access_e t);
      return (t == ACC_READ_BYTE) || (t == ACC_READ_HALF) || (t == ACC_READ_WORD);
   endfunction

   function automatic logic acc_is_write(input mem_access_e t);
      return (t == ACC_WRITE_BYTE) || (t == ACC_WRITE_HALF) || (t == ACC_WRITE_WORD);
   endfunction

   function automatic acc_size_e acc_size(input mem_access_e t);
      case (t)
         ACC_READ_BYTE, ACC_WRITE_BYTE: return SZ_BYTE;
         ACC_READ_HALF, ACC_WRITE_HALF: return SZ_HALF;
         default:                       return SZ_WORD;
      endcase
   endfunction

   function automatic logic acc_aligned(input mem_access_e t, input logic [1:0] a);
      case (acc_size(t))
         SZ_BYTE: return 1'b1;
         SZ_HALF: return (a[0] == 1'b0);
         default: return (a == 2'b00);
      endcase
   endfunction

   function automatic logic [3:0] lane_mask(input mem_access_e t, input logic [1:0] a);
      if (!(acc_is_read(t) || acc_is_write(t))) return 4'b0000;
      case (acc_size(t))
         SZ_BYTE: return 4'b0001 << a;
         SZ_HALF: return a[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/bus_timer.sv
// bus_timer
//   Prescaled 32-bit up counter with compare match, W1C pending flag and
//   level interrupt, accessed through a simple word-wide register port.
// Ports
//   clk, rst_n   core clock, async active-low reset
//   wr_en_i      register write strobe (decoded, word access)
//   addr_i       register offset within the timer window
//   wdata_i      write data
//   rdata_o      combinational read data for addr_i
//   irq_o        pending & irq_en
module bus_timer
   import sys_bus_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en_i,
   input  logic [4:0]  addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        irq_o
);

   logic        en_q, en_d;
   logic        irq_en_q, irq_en_d;
   logic        auto_reload_q, auto_reload_d;
   logic [15:0] presc_q, presc_d;
   logic [15:0] pcnt_q, pcnt_d;
   logic [31:0] count_q, count_d;
   logic [31:0] cmp_q, cmp_d;
   logic        pending_q, pending_d;
   logic        tick;
   logic        match;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q          <= 1'b0;
         irq_en_q      <= 1'b0;
         auto_reload_q <= 1'b0;
         presc_q       <= '0;
         pcnt_q        <= '0;
         count_q       <= '0;
         cmp_q         <= '0;
         pending_q     <= 1'b0;
      end else begin
         en_q          <= en_d;
         irq_en_q      <= irq_en_d;
         auto_reload_q <= auto_reload_d;
         presc_q       <= presc_d;
         pcnt_q        <= pcnt_d;
         count_q       <= count_d;
         cmp_q         <= cmp_d;
         pending_q     <= pending_d;
      end
   end

   always_comb begin
      en_d          = en_q;
      irq_en_d      = irq_en_q;
      auto_reload_d = auto_reload_q;
      presc_d       = presc_q;
      pcnt_d        = pcnt_q;
      count_d       = count_q;
      cmp_d         = cmp_q;
      pending_d     = pending_q;

      tick  = en_q && (pcnt_q == presc_q);
      match = tick && (count_q == cmp_q);

      // Counters only move while enabled, so clearing en freezes them in place
      if (en_q) begin
         pcnt_d = tick ? '0 : pcnt_q + 16'd1;
      end
      if (tick) begin
         count_d = (match && auto_reload_q) ? '0 : count_q + 32'd1;
      end

      // Register writes come after the tick update so a COUNT write wins
      if (wr_en_i) begin
         case (addr_i)
            TMR_CTRL: begin
               en_d          = wdata_i[CTRL_EN];
               irq_en_d      = wdata_i[CTRL_IRQ_EN];
               auto_reload_d = wdata_i[CTRL_AUTO_RELOAD];
            end
            TMR_PRESC: begin
               presc_d = wdata_i[15:0];
               pcnt_d  = '0;
            end
            TMR_COUNT: count_d = wdata_i;
            TMR_CMP:   cmp_d   = wdata_i;
            TMR_STAT:  if (wdata_i[0]) pending_d = 1'b0;
            default: ;
         endcase
      end

      // A match on this tick overrides a simultaneous W1C
      if (match) pending_d = 1'b1;
   end

   always_comb begin
      case (addr_i)
         TMR_CTRL:  rdata_o = {29'd0, auto_reload_q, irq_en_q, en_q};
         TMR_PRESC: rdata_o = {16'd0, presc_q};
         TMR_COUNT: rdata_o = count_q;
         TMR_CMP:   rdata_o = cmp_q;
         TMR_STAT:  rdata_o = {31'd0, pending_q};
         default:   rdata_o = '0;
      endcase
   end

   assign irq_o = pending_q & irq_en_q;

endmodule

// File: rtl/sys_bus_ctrl.sv
// sys_bus_ctrl
//   Data-side system bus slave: decodes each core access to a word-organised
//   byte-enabled data RAM or the timer block, steers byte/half/word lanes,
//   flags misaligned/unmapped accesses and returns registered read data.
// Ports
//   clk, rst_n            core clock, async active-low reset
//   sys_bus_addr_i        byte address (0 when idle)
//   sys_bus_access_type   access type (mem_access_e encoding)
//   sys_bus_wdata_i       write data, right-aligned
//   sys_bus_rdata_o       registered read data, right-aligned, zero-extended
//   timer_irq_o           timer level interrupt
//   bus_err_o             sticky misaligned/unmapped flag, cleared by ERR write
module sys_bus_ctrl
   import sys_bus_ctrl_pkg::*;
#(
   parameter int unsigned RAM_DEPTH  = 1024,
   parameter logic [31:0] RAM_BASE   = 32'h0000_0000,
   parameter logic [31:0] TIMER_BASE = 32'h1000_0000
)(
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [31:0]                      sys_bus_addr_i,
   input  logic [MEM_ACCESS_TYPE_WIDTH-1:0] sys_bus_access_type,
   input  logic [31:0]                      sys_bus_wdata_i,
   output logic [31:0]                      sys_bus_rdata_o,
   output logic                             timer_irq_o,
   output logic                             bus_err_o
);

   localparam int unsigned IDX_W     = $clog2(RAM_DEPTH);
   localparam logic [31:0] RAM_BYTES = 32'(RAM_DEPTH * 4);

   mem_access_e acc;
   logic        is_rd, is_wr, active;
   logic        hit_ram, hit_tmr;
   logic        tmr_reg, err_reg;
   logic        access_ok, fault;
   logic        ram_we;
   logic [3:0]  ram_be;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rd_word;
   logic [IDX_W-1:0] ram_idx;
   logic [4:0]  tmr_off;
   logic        tmr_wr, err_clr;
   logic [31:0] tmr_rdata;

   logic [31:0] rdata_q, rdata_d;
   logic        bus_err_q, bus_err_d;
   logic [31:0] err_addr_q, err_addr_d;

   logic [31:0] mem [RAM_DEPTH];

   assign acc     = mem_access_e'(sys_bus_access_type);
   assign hit_ram = in_window(sys_bus_addr_i, RAM_BASE, RAM_BYTES);
   assign hit_tmr = in_window(sys_bus_addr_i, TIMER_BASE, TMR_WINDOW_BYTES);
   assign ram_idx = IDX_W'((sys_bus_addr_i - RAM_BASE) >> 2);
   assign tmr_off = 5'(sys_bus_addr_i - TIMER_BASE);

   // Decode and lane steering
   always_comb begin
      is_rd   = acc_is_read(acc);
      is_wr   = acc_is_write(acc);
      active  = is_rd || is_wr;
      tmr_reg = tmr_off inside {TMR_CTRL, TMR_PRESC, TMR_COUNT, TMR_CMP, TMR_STAT};
      err_reg = (tmr_off == TMR_ERR);

      // Timer block only accepts word accesses to implemented registers
      access_ok = active && acc_aligned(acc, sys_bus_addr_i[1:0]) &&
                  (hit_ram || (hit_tmr && (acc_size(acc) == SZ_WORD) && (tmr_reg || err_reg)));
      fault     = active && !access_ok;

      ram_we  = is_wr && access_ok && hit_ram;
      ram_be  = lane_mask(acc, sys_bus_addr_i[1:0]);
      tmr_wr  = is_wr && access_ok && !hit_ram && hit_tmr && tmr_reg;
      err_clr = is_wr && access_ok && !hit_ram && hit_tmr && err_reg;

      case (acc_size(acc))
         SZ_BYTE: ram_wdata = {4{sys_bus_wdata_i[7:0]}};
         SZ_HALF: ram_wdata = {2{sys_bus_wdata_i[15:0]}};
         default: ram_wdata = sys_bus_wdata_i;
      endcase
   end

   // Reset low at the edge suppresses the write so an aborted access leaves RAM intact
   always_ff @(posedge clk) begin
      if (rst_n && ram_we) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (ram_be[b]) mem[ram_idx][b*8 +: 8] <= ram_wdata[b*8 +: 8];
         end
      end
   end

   assign ram_rd_word = mem[ram_idx];

   bus_timer u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en_i (tmr_wr),
      .addr_i  (tmr_off),
      .wdata_i (sys_bus_wdata_i),
      .rdata_o (tmr_rdata),
      .irq_o   (timer_irq_o)
   );

   // Read mux and error capture
   always_comb begin
      rdata_d    = rdata_q;
      bus_err_d  = bus_err_q;
      err_addr_d = err_addr_q;

      if (is_rd) begin
         if (!access_ok) begin
            rdata_d = '0;
         end else if (hit_ram) begin
            case (acc_size(acc))
               SZ_BYTE: rdata_d = {24'd0, ram_rd_word[{sys_bus_addr_i[1:0], 3'b000} +: 8]};
               SZ_HALF: rdata_d = {16'd0, ram_rd_word[{sys_bus_addr_i[1], 4'b0000} +: 16]};
               default: rdata_d = ram_rd_word;
            endcase
         end else if (err_reg) begin
            rdata_d = err_addr_q;
         end else begin
            rdata_d = tmr_rdata;
         end
      end

      if (fault) begin
         bus_err_d  = 1'b1;
         err_addr_d = sys_bus_addr_i;
      end else if (err_clr) begin
         bus_err_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q    <= '0;
         bus_err_q  <= 1'b0;
         err_addr_q <= '0;
      end else begin
         rdata_q    <= rdata_d;
         bus_err_q  <= bus_err_d;
         err_addr_q <= err_addr_d;
      end
   end

   assign sys_bus_rdata_o = rdata_q;
   assign bus_err_o       = bus_err_q;

endmodule
